// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: multiply/divide op encodings and the
// multiply/divide unit's control-state encodings.
package cpu_defs_pkg;

  // HI/LO unit operation select. Bit 1 selects divide; bit 0 selects unsigned.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  // Multiply/divide control states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement: passes the input through, or negates it
// when neg is set. Used both to form operand magnitudes and to restore
// the sign of results.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  // Negate as invert-plus-one; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign out = neg ? (~in + {{(W-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit feeding HI/LO. One shift-add (multiply)
// or restoring-divide step per clock on operand magnitudes, followed by a
// sign-correction cycle that loads hi/lo and pulses done.
module mult_div_unit
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t          state;
  md_op_t             op_reg;
  logic [CNT_W-1:0]   cnt;
  logic               sa_reg;
  logic               sb_reg;
  // Multiply: {partial product upper, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] p_reg;
  // Multiplicand magnitude or divisor magnitude.
  logic [WIDTH-1:0]   d_reg;

  logic               op_is_div;
  logic               op_is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Operand signs only matter for the signed forms.
  assign op_is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign op_is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg        = op_is_signed & a[WIDTH-1];
  assign b_neg        = op_is_signed & b[WIDTH-1];

  md_sign_fix #(.W(WIDTH)) a_mag_fix (.in(a), .neg(a_neg), .out(a_mag));
  md_sign_fix #(.W(WIDTH)) b_mag_fix (.in(b), .neg(b_neg), .out(b_mag));

  // One multiply step: conditionally add the multiplicand into the upper
  // half, then shift the whole product right with the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, d_reg} : '0);
  assign mul_next = {mul_sum, p_reg[WIDTH-1:1]};

  // One restoring-divide step: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, shift in the quotient bit.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = p_reg[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, d_reg};
  // Only taken when div_ge, so the result always fits in WIDTH bits.
  assign div_sub   = div_shift[WIDTH-1:0] - d_reg;
  assign div_next  = div_ge ? {div_sub, p_reg[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0};

  // Sign correction of the finished magnitudes.
  logic               res_signed;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res;
  logic [WIDTH-1:0]   rem_res;
  assign res_signed = (op_reg == MD_MULT) || (op_reg == MD_DIV);

  md_sign_fix #(.W(2*WIDTH)) prod_fix (
    .in(p_reg), .neg(res_signed & (sa_reg ^ sb_reg)), .out(prod_res));
  md_sign_fix #(.W(WIDTH)) quot_fix (
    .in(p_reg[WIDTH-1:0]), .neg(res_signed & (sa_reg ^ sb_reg)), .out(quot_res));
  md_sign_fix #(.W(WIDTH)) rem_fix (
    .in(p_reg[2*WIDTH-1:WIDTH]), .neg(res_signed & sa_reg), .out(rem_res));

  // Control FSM with registered busy/done/div0 and hi/lo result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      op_reg <= MD_MULT;
      cnt    <= '0;
      sa_reg <= 1'b0;
      sb_reg <= 1'b0;
      p_reg  <= '0;
      d_reg  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            if (op_is_div && (b == '0)) begin
              // Divide by zero: flag it immediately, leave hi/lo alone.
              done <= 1'b1;
              div0 <= 1'b1;
            end else begin
              state  <= MD_CALC;
              busy   <= 1'b1;
              div0   <= 1'b0;
              op_reg <= md_op_t'(op);
              sa_reg <= a_neg;
              sb_reg <= b_neg;
              cnt    <= CNT_W'(WIDTH);
              d_reg  <= b_mag;
              p_reg  <= {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
        MD_CALC: begin
          p_reg <= (op_reg == MD_DIV || op_reg == MD_DIVU) ? div_next : mul_next;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= MD_FIX;
        end
        MD_FIX: begin
          if (op_reg == MD_DIV || op_reg == MD_DIVU) begin
            hi <= rem_res;
            lo <= quot_res;
          end else begin
            hi <= prod_res[2*WIDTH-1:WIDTH];
            lo <= prod_res[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with hand-computed
// results plus randomized operations checked every cycle against a
// behavioural model built on plain 64-bit arithmetic.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: returns {hi, lo} for a non-div0 operation.
  function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'd0: res = 64'(sx * sy);
      2'd1: res = ux * uy;
      2'd2: begin
        q = sx / sy;
        r = sx % sy;
        res = {32'(r), 32'(q)};
      end
      default: res = {32'(ux % uy), 32'(ux / uy)};
    endcase
    return res;
  endfunction

  // Behavioural model: a result becomes visible WIDTH+1 edges after it is
  // accepted; new requests are only taken when nothing is outstanding.
  logic        m_busy, m_done, m_div0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_div0 <= 0;
      m_hi <= 0; m_lo <= 0; m_cnt <= 0; m_pend <= 0;
    end else begin
      m_done <= 0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 0;
          m_done <= 1;
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end else if (start) begin
        if (op >= 2'd2 && b == 0) begin
          m_done <= 1;
          m_div0 <= 1;
        end else begin
          m_pend <= ref_calc(op, a, b);
          m_div0 <= 0;
          m_busy <= 1;
          m_cnt  <= WIDTH + 1;
        end
      end
    end
  end

  // Every cycle, the DUT outputs must equal the model's.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, done, div0, hi, lo} !== {m_busy, m_done, m_div0, m_hi, m_lo}) begin
        failures++;
        $display("FAIL cycle_compare t=%0t got busy=%b done=%b div0=%b hi=%h lo=%h exp busy=%b done=%b div0=%b hi=%h lo=%h",
                 $time, busy, done, div0, hi, lo, m_busy, m_done, m_div0, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issue one request (caller is mid-cycle, before the accepting edge) and
  // wait for done. edges = clock edges after the accepting edge until done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rd0,
                        output int edges, output int busy_n);
    op = o; a = x; b = y; start = 1;
    @(posedge clk); #2;
    start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
    edges = 0;
    busy_n = busy ? 1 : 0;
    if (!done) begin
      while (edges < 40) begin
        @(posedge clk); #1;
        edges++;
        if (busy) busy_n++;
        if (done) break;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout op=%0d a=%h b=%h", o, x, y);
    end
    rh = hi; rl = lo; rd0 = div0;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h div0=%b edges=%0d", o, x, y, rh, rl, rd0, edges);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] rh, rl;
  logic        rd0;
  int          edges, busy_n, done_seen;

  initial begin
    reset = 0; start = 0; op = 0; a = 0; b = 0;
    #1 reset = 1;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {31'b0, busy, done, div0, hi, lo}, 64'h0);
    #1 reset = 0;

    // Signed multiply, negative times positive.
    @(posedge clk); #2;
    run_op(2'd0, 32'hFFFF_FFFD, 32'h7, rh, rl, rd0, edges, busy_n);
    check("mult_hilo", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_div0", {63'b0, rd0}, 64'h0);
    check("mult_latency", 64'(edges), 64'd33);

    // Largest unsigned product; busy exactly WIDTH+1 cycles.
    @(posedge clk); #2;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rd0, edges, busy_n);
    check("multu_hilo", {rh, rl}, 64'hFFFF_FFFE_0000_0001);
    check("multu_busy_cycles", 64'(busy_n), 64'd33);

    // Signed divide truncates toward zero; chained DIVU in the done cycle.
    @(posedge clk); #2;
    run_op(2'd2, 32'hFFFF_FFF9, 32'h2, rh, rl, rd0, edges, busy_n);
    check("div_neg_hilo", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'h7, 32'h2, rh, rl, rd0, edges, busy_n);
    check("divu_chained_hilo", {rh, rl}, 64'h0000_0001_0000_0003);
    check("divu_chained_latency", 64'(edges), 64'd33);

    // Most negative over -1 wraps with no flag.
    @(posedge clk); #2;
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rd0, edges, busy_n);
    check("div_ovf_hilo", {rh, rl}, 64'h0000_0000_8000_0000);
    check("div_ovf_div0", {63'b0, rd0}, 64'h0);

    // Divide by zero leaves the previous hi=5, lo=9 in place.
    @(posedge clk); #2;
    run_op(2'd3, 32'd68, 32'd7, rh, rl, rd0, edges, busy_n);
    check("divu_prior_hilo", {rh, rl}, 64'h0000_0005_0000_0009);
    @(posedge clk); #2;
    run_op(2'd3, 32'd1234, 32'd0, rh, rl, rd0, edges, busy_n);
    check("div0_flag", {63'b0, rd0}, 64'h1);
    check("div0_hilo", {rh, rl}, 64'h0000_0005_0000_0009);
    check("div0_latency", 64'(edges), 64'd0);
    check("div0_busy", 64'(busy_n), 64'd0);
    @(posedge clk); #2;
    run_op(2'd1, 32'd6, 32'd7, rh, rl, rd0, edges, busy_n);
    check("div0_cleared", {31'b0, rd0, rh, rl}, 64'd42);

    // Start during iteration is ignored; reset mid-operation aborts it.
    @(posedge clk); #2;
    op = 2'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1;
    @(posedge clk); #2;
    start = 0;
    repeat (4) @(posedge clk);
    #2 op = 2'd3; a = 32'd100; b = 32'd0; start = 1;
    @(posedge clk); #2;
    start = 0;
    check("start_ignored_busy", {63'b0, busy}, 64'h1);
    repeat (4) @(posedge clk);
    #2 reset = 1;
    #1 check("midop_reset_outputs", {31'b0, busy, done, div0, hi, lo}, 64'h0);
    @(posedge clk); #2 reset = 0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("no_done_after_reset", 64'(done_seen), 64'd0);

    // Randomized operations, sometimes chained into the done cycle, while
    // the inputs are scrambled during iteration.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        @(posedge clk); #2;
      end
      run_op(2'($urandom), rand_val(), rand_val(), rh, rl, rd0, edges, busy_n);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
